sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving SRAM cycles per 16-bit half access (legal range 1..15).
REQ-002 The block SHALL have parameter BASE_ADDR, default 1024, giving the CPU byte address that maps to SRAM word 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write request from the MEM stage.
REQ-006 The block SHALL have port rd_en, input, 1 bit: read request from the MEM stage.
REQ-007 The block SHALL have port address, input, 32 bits: CPU byte address (ALU result).
REQ-008 The block SHALL have port write_data, input, 32 bits: store data (Rm value).
REQ-009 The block SHALL have port read_data, output, 32 bits: registered load result.
REQ-010 The block SHALL have port ready, output, 1 bit: request done; the pipeline freeze is ~ready.
REQ-011 The block SHALL have port sram_addr, output, 18 bits: SRAM half-word address.
REQ-012 The block SHALL have ports sram_dq_out (output, 16 bits), sram_dq_in (input, 16 bits) and sram_dq_oe (output, 1 bit): the split data bus, with oe=1 meaning the block drives the bus.
REQ-013 The block SHALL have port sram_we_n, output, 1 bit: SRAM write strobe, active-low.

Function
REQ-014 FSM states SHALL be IDLE, LOW, HIGH and DONE, with a 4-bit wait counter.
REQ-015 IDLE SHALL go to LOW when (rd_en | wr_en) is sampled, and SHALL otherwise stay in IDLE.
REQ-016 LOW SHALL last WAIT_CYCLES cycles and then go to HIGH; HIGH SHALL last WAIT_CYCLES cycles and then go to DONE; DONE SHALL last 1 cycle and then go to IDLE unconditionally.
REQ-017 ready SHALL be combinational: 0 in IDLE when a request is present, 0 in LOW and HIGH, and 1 in DONE and in IDLE with no request.
REQ-018 A request SHALL complete in 2*WAIT_CYCLES+2 cycles including the request cycle (6 cycles with the default WAIT_CYCLES=2).
REQ-019 The requester SHALL hold address, data and enables stable while ready=0; the block SHALL NOT register them.
REQ-020 A request still asserted in DONE SHALL be treated as the completed one and SHALL NOT restart the FSM.
REQ-021 offset SHALL be (address - BASE_ADDR) mod 2^32, and sram_addr SHALL be {offset[18:2], half}, where half=0 in LOW and half=1 in HIGH.
REQ-022 address[1:0] and offset[31:19] SHALL be ignored, so out-of-range addresses wrap without error.
REQ-023 sram_addr SHALL be 0 in IDLE and DONE.
REQ-024 For a write, sram_we_n SHALL be 0 and sram_dq_oe SHALL be 1 for every LOW/HIGH cycle; sram_dq_out SHALL be write_data[15:0] in LOW and write_data[31:16] in HIGH.
REQ-025 For a read, sram_we_n SHALL be 1 and sram_dq_oe SHALL be 0.
REQ-026 For a read, sram_dq_in SHALL be captured into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
REQ-027 read_data SHALL hold its value until the next read completes, and writes SHALL NOT modify it.
REQ-028 When rd_en and wr_en are both asserted, the block SHALL perform a write only.
REQ-029 Outside LOW/HIGH write cycles, sram_we_n SHALL be 1, sram_dq_oe SHALL be 0 and sram_dq_out SHALL be 0.

Reset
REQ-030 When rst is sampled, the block SHALL set state=IDLE, counter=0, read_data=0, sram_we_n=1, sram_dq_oe=0 and sram_addr=0.
REQ-031 ready SHALL be 1 while rst is high, regardless of rd_en or wr_en.
REQ-032 Reset during LOW or HIGH SHALL abort the access immediately, with no partial update of read_data beyond halves already captured before the reset cycle.

Configuration
REQ-033 With macro SRAM_READ_BUF_EN defined, the block SHALL keep a one-entry buffer: a valid bit plus the 17-bit word index of the last completed read.
REQ-034 With SRAM_READ_BUF_EN defined, a read in IDLE whose word index matches a valid buffer SHALL hit: ready=1 in that same cycle, no SRAM access, FSM stays in IDLE, read_data unchanged.
REQ-035 With SRAM_READ_BUF_EN defined, a write to the buffered word index SHALL clear valid, reset SHALL clear valid, and each completed read SHALL set valid and load its index.
REQ-036 Without SRAM_READ_BUF_EN, every read SHALL use the full FSM sequence, and no buffer logic SHALL exist.

Verification
REQ-037 Write 0xDEADBEEF to address 1024 (W=2): ready=0 for cycles 0-4 and 1 in cycle 5; sram_addr 0 then 1; sram_dq_out 0xBEEF then 0xDEAD; sram_we_n=0 for 4 cycles.
REQ-038 Read address 1024 with a bench SRAM model holding 0xDEADBEEF: read_data=0xDEADBEEF at cycle 5 and held thereafter.
REQ-039 Address 1020 (below base): sram_addr upper bits = 0x1FFFF (wrap); rd_en and wr_en both high -> write strobes only, read_data unchanged.
REQ-040 Assert rst during the second HIGH cycle: next cycle IDLE, ready=1, read_data=0, sram_we_n=1.
REQ-041 With SRAM_READ_BUF_EN: two back-to-back reads of 2048 -> second completes with ready=1 in its request cycle; an intervening write to 2048 -> the second read takes 6 cycles.

Source files
------------

// File: rtl/sram_controller_if.sv
// ---------------------------------------------------------------------------
// sram_controller_if
//   Signal bundle between the CPU MEM stage / external SRAM and the
//   sram_controller.
//
//   CPU side  : wr_en, rd_en, address, write_data -> controller
//               read_data, ready                  <- controller
//   SRAM side : sram_addr, sram_dq_out, sram_dq_oe, sram_we_n <- controller
//               sram_dq_in                                    -> controller
//
//   The master modport is the environment, which owns both the CPU request
//   and the SRAM read data. The slave modport is the controller.
// ---------------------------------------------------------------------------
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//   Maps 32-bit CPU loads/stores onto a 16-bit asynchronous SRAM as two
//   half-word accesses (low half, then high half), each WAIT_CYCLES long,
//   followed by a single DONE cycle. A request takes 2*WAIT_CYCLES+2 cycles
//   including the cycle it is first seen.
//
//   Parameters : WAIT_CYCLES (1..15) cycles per half access
//                BASE_ADDR   CPU byte address of SRAM word 0
//   Ports      : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - sram_controller_if.slave (CPU request + SRAM bus)
//
//   Optional   : define SRAM_READ_BUF_EN to add a one-entry read buffer that
//                lets a repeated read of the last completed word finish in
//                its request cycle without touching the SRAM.
//
//   The requester holds address/data/enables stable while ready=0, so they
//   are used directly rather than registered.
// ---------------------------------------------------------------------------
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rd_data_q;

    logic [31:0] offset;
    logic [16:0] word_idx;
    logic        unused_offset_bits;
    logic        req, is_rd, start, buf_hit;
    logic        active, wr_act, cnt_last;

    // Offset wraps mod 2^32; byte lane bits and bits above the SRAM size
    // are dropped, so out-of-range addresses simply alias.
    assign offset             = bus.address - BASE_ADDR;
    assign word_idx           = offset[18:2];
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    // A simultaneous read+write is a write.
    assign req      = bus.rd_en | bus.wr_en;
    assign is_rd    = bus.rd_en & ~bus.wr_en;
    assign cnt_last = (cnt_q == CNT_LAST);

`ifdef SRAM_READ_BUF_EN
    logic        buf_vld_q;
    logic [16:0] buf_idx_q;

    assign buf_hit = buf_vld_q & is_rd & (state_q == IDLE) & (word_idx == buf_idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q <= 1'b0;
            buf_idx_q <= '0;
        end else if (state_q == DONE) begin
            if (is_rd) begin
                buf_vld_q <= 1'b1;
                buf_idx_q <= word_idx;
            end else if (bus.wr_en && word_idx == buf_idx_q) begin
                // Store to the buffered word makes the copy stale.
                buf_vld_q <= 1'b0;
            end
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    assign start = req & ~buf_hit;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (cnt_last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                if (cnt_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            // A request still held here is the one just completed.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM strobes are gated by rst so a reset aborts the access in the
    // very cycle it is asserted.
    assign active = ((state_q == LOW) || (state_q == HIGH)) && !rst;
    assign wr_act = active & bus.wr_en;

    assign bus.ready       = rst | (state_q == DONE) | ((state_q == IDLE) & ~start);
    assign bus.sram_addr   = active ? {word_idx, (state_q == HIGH)} : 18'd0;
    assign bus.sram_we_n   = ~wr_act;
    assign bus.sram_dq_oe  = wr_act;
    assign bus.sram_dq_out = !wr_act           ? 16'd0 :
                             (state_q == HIGH) ? bus.write_data[31:16] :
                                                 bus.write_data[15:0];
    assign bus.read_data   = rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Capture each half on the last cycle of its access window.
            if (is_rd && cnt_last) begin
                if (state_q == LOW)  rd_data_q[15:0]  <= bus.sram_dq_in;
                if (state_q == HIGH) rd_data_q[31:16] <= bus.sram_dq_in;
            end
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
//   Directed bench for sram_controller (WAIT_CYCLES=2, BASE_ADDR=1024).
//   Inputs change 1 time unit after a rising edge; outputs are checked one
//   unit later, mid-cycle. A small read-only SRAM model feeds sram_dq_in.
// ---------------------------------------------------------------------------
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   n;

`ifdef SRAM_READ_BUF_EN
    localparam int HIT_CYCLES = 1;
`else
    localparam int HIT_CYCLES = 6;
`endif

    logic [15:0] mem [0:262143];

    sram_controller_if bus ();

    sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.sram_dq_in = mem[bus.sram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all handshake/strobe outputs for the current cycle.
    task automatic cyc(input string tag, input logic e_rdy, input logic e_we_n,
                       input logic e_oe, input logic [17:0] e_addr, input logic [15:0] e_dq);
        #1;
        chk({tag, ".ready"},    32'(bus.ready),       32'(e_rdy));
        chk({tag, ".we_n"},     32'(bus.sram_we_n),   32'(e_we_n));
        chk({tag, ".oe"},       32'(bus.sram_dq_oe),  32'(e_oe));
        chk({tag, ".addr"},     32'(bus.sram_addr),   32'(e_addr));
        chk({tag, ".dq_out"},   32'(bus.sram_dq_out), 32'(e_dq));
    endtask

    // Start a request next cycle and hold it until ready; ncyc counts the
    // cycles including the request cycle (capped at 20).
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, output int ncyc);
        tick();
        bus.rd_en = rd; bus.wr_en = wr; bus.address = addr; bus.write_data = data;
        ncyc = 1;
        forever begin
            #1;
            if (bus.ready || ncyc >= 20) break;
            tick();
            ncyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0]     = 16'hBEEF; mem[1]   = 16'hDEAD;
        mem[2]     = 16'h1111; mem[3]   = 16'h2222;
        mem[512]   = 16'hAAAA; mem[513] = 16'h5555;
        rst = 1'b1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;

        // Reset state
        tick(); tick();
        cyc("rst", 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);
        chk("rst.read_data", bus.read_data, 32'h0);
        bus.rd_en = 1'b1; #1;
        chk("rst.ready_with_req", 32'(bus.ready), 32'd1);
        bus.rd_en = 1'b0; rst = 1'b0;
        tick();
        cyc("idle", 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);

        // Write 0xDEADBEEF to 1024
        tick(); bus.wr_en = 1'b1; bus.address = 32'd1024; bus.write_data = 32'hDEADBEEF;
        cyc("w0", 1'b0, 1'b1, 1'b0, 18'h0, 16'h0);
        tick(); cyc("w1", 1'b0, 1'b0, 1'b1, 18'h0, 16'hBEEF);
        tick(); cyc("w2", 1'b0, 1'b0, 1'b1, 18'h0, 16'hBEEF);
        tick(); cyc("w3", 1'b0, 1'b0, 1'b1, 18'h1, 16'hDEAD);
        tick(); cyc("w4", 1'b0, 1'b0, 1'b1, 18'h1, 16'hDEAD);
        tick(); cyc("w5", 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);
        chk("w5.read_data", bus.read_data, 32'h0);

        // Read 1024
        tick(); bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.address = 32'd1024;
        cyc("r0", 1'b0, 1'b1, 1'b0, 18'h0, 16'h0);
        tick(); cyc("r1", 1'b0, 1'b1, 1'b0, 18'h0, 16'h0);
        tick(); cyc("r2", 1'b0, 1'b1, 1'b0, 18'h0, 16'h0);
        tick(); cyc("r3", 1'b0, 1'b1, 1'b0, 18'h1, 16'h0);
        chk("r3.read_data_low", bus.read_data, 32'h0000BEEF);
        tick(); cyc("r4", 1'b0, 1'b1, 1'b0, 18'h1, 16'h0);
        tick(); cyc("r5", 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);
        chk("r5.read_data", bus.read_data, 32'hDEADBEEF);
        tick(); bus.rd_en = 1'b0; #1;
        chk("r.hold1", bus.read_data, 32'hDEADBEEF);
        tick(); #1;
        chk("r.hold2", bus.read_data, 32'hDEADBEEF);

        // Below-base address, read+write together -> wrapped write only
        tick(); bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.address = 32'd1020; bus.write_data = 32'h12345678;
        cyc("x0", 1'b0, 1'b1, 1'b0, 18'h0, 16'h0);
        tick(); cyc("x1", 1'b0, 1'b0, 1'b1, 18'h3FFFE, 16'h5678);
        tick(); cyc("x2", 1'b0, 1'b0, 1'b1, 18'h3FFFE, 16'h5678);
        tick(); cyc("x3", 1'b0, 1'b0, 1'b1, 18'h3FFFF, 16'h1234);
        tick(); cyc("x4", 1'b0, 1'b0, 1'b1, 18'h3FFFF, 16'h1234);
        tick(); cyc("x5", 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);
        chk("x5.read_data", bus.read_data, 32'hDEADBEEF);
        tick(); bus.rd_en = 1'b0; bus.wr_en = 1'b0; #1;
        chk("x.hold", bus.read_data, 32'hDEADBEEF);

        // Reset during the second HIGH cycle of a read of 1028
        tick(); bus.rd_en = 1'b1; bus.address = 32'd1028;
        tick(); tick(); tick(); #1;
        chk("a3.read_data_low", bus.read_data, 32'hDEAD1111);
        chk("a3.addr", 32'(bus.sram_addr), 32'h3);
        tick(); rst = 1'b1; #1;
        chk("a4.ready_in_rst", 32'(bus.ready), 32'd1);
        chk("a4.we_n_in_rst", 32'(bus.sram_we_n), 32'd1);
        tick(); rst = 1'b0; bus.rd_en = 1'b0;
        cyc("a5", 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);
        chk("a5.read_data", bus.read_data, 32'h0);

        // Repeated reads of 2048, with and without an intervening write
        run_req(1'b1, 1'b0, 32'd2048, 32'h0, n);
        chk("b.first_read_cycles", 32'(n), 32'd6);
        chk("b.first_read_data", bus.read_data, 32'h5555AAAA);
        run_req(1'b1, 1'b0, 32'd2048, 32'h0, n);
        chk("b.second_read_cycles", 32'(n), 32'(HIT_CYCLES));
        chk("b.second_read_data", bus.read_data, 32'h5555AAAA);
        run_req(1'b0, 1'b1, 32'd2048, 32'hCAFEF00D, n);
        chk("b.write_cycles", 32'(n), 32'd6);
        run_req(1'b1, 1'b0, 32'd2048, 32'h0, n);
        chk("b.read_after_write_cycles", 32'(n), 32'd6);
        tick(); bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        cyc("b.idle", 1'b1, 1'b1, 1'b0, 18'h0, 16'h0);
        chk("b.read_data_held", bus.read_data, 32'h5555AAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
